// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- MEM-stage data memory controller
//
// Takes one load/store request from the MEM stage and runs it through a
// three-state sequence: IDLE (accept), ACCESS (one RAM cycle), DONE (result
// held until the pipeline releases it). Byte lanes are big-endian: byte
// offset 0 lives in ram bits [31:24] and is enabled by ram_sel_o[3].
//
// Handshake: a request is taken when req_i=1 in IDLE, with no flush and not
// in the first cycle after reset. stallreq_o is high from that cycle through
// ACCESS. done_o marks the cycle(s) where rdata_o/align_exc_o are valid, and
// it stays high while stall_i holds the pipeline. The request is never
// re-issued on its own.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req_i             MEM-stage request valid
//   mem_op_i[2:0]     LB/LBU/LH/LHU/LW/SB/SH/SW
//   addr_i[31:0]      byte address
//   wdata_i[31:0]     right-aligned store data
//   stall_i           pipeline hold (MEM inputs stable while high)
//   flush_i           pipeline flush, forces IDLE next cycle
//   stallreq_o        stall request to pipeline control
//   done_o            access complete
//   rdata_o[31:0]     extended load result (0 for stores/misaligned)
//   align_exc_o       misaligned access, only in DONE
//   ram_ce_o/we_o     RAM chip/write enable, only in ACCESS
//   ram_addr_o[31:0]  word-aligned RAM address
//   ram_sel_o[3:0]    byte lane enables
//   ram_data_o[31:0]  replicated store data
//   ram_data_i[31:0]  RAM read data, combinational from ram_addr_o
// -----------------------------------------------------------------------------
module dmem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [2:0]  mem_op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        stallreq_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        align_exc_o,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [31:0] ram_addr_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_align;
   // Low for the first cycle after reset so no request is taken there.
   logic        r_rst_q;

   logic        w_is_store;
   logic        w_is_byte;
   logic        w_is_half;
   logic        w_is_word;
   logic        w_misalign;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic        w_accept;
   logic        w_in_access;

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_is_store = 1'b0;
      w_is_byte  = 1'b0;
      w_is_half  = 1'b0;
      w_is_word  = 1'b0;
      case (r_op)
         OP_LB, OP_LBU: w_is_byte = 1'b1;
         OP_LH, OP_LHU: w_is_half = 1'b1;
         OP_LW:         w_is_word = 1'b1;
         OP_SB: begin w_is_byte = 1'b1; w_is_store = 1'b1; end
         OP_SH: begin w_is_half = 1'b1; w_is_store = 1'b1; end
         OP_SW: begin w_is_word = 1'b1; w_is_store = 1'b1; end
         default: ;
      endcase
   end

   assign w_misalign = (w_is_half & r_addr[0]) | (w_is_word & (r_addr[1:0] != 2'b00));

   // Lane enables and replicated store data (big-endian lanes).
   always_comb begin
      w_sel   = 4'b0000;
      w_wdata = 32'd0;
      if (w_is_byte) begin
         case (r_addr[1:0])
            2'd0:    w_sel = 4'b1000;
            2'd1:    w_sel = 4'b0100;
            2'd2:    w_sel = 4'b0010;
            default: w_sel = 4'b0001;
         endcase
      end else if (w_is_half) begin
         w_sel = r_addr[1] ? 4'b0011 : 4'b1100;
      end else if (w_is_word) begin
         w_sel = 4'b1111;
      end
      if (w_is_store) begin
         if (w_is_byte)      w_wdata = {4{r_wdata[7:0]}};
         else if (w_is_half) w_wdata = {2{r_wdata[15:0]}};
         else                w_wdata = r_wdata;
      end
   end

   // Load lane extraction and extension.
   always_comb begin
      w_byte = 8'd0;
      case (r_addr[1:0])
         2'd0:    w_byte = ram_data_i[31:24];
         2'd1:    w_byte = ram_data_i[23:16];
         2'd2:    w_byte = ram_data_i[15:8];
         default: w_byte = ram_data_i[7:0];
      endcase
      w_half = r_addr[1] ? ram_data_i[15:0] : ram_data_i[31:16];
      w_load = 32'd0;
      case (r_op)
         OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load = {24'd0, w_byte};
         OP_LH:   w_load = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load = {16'd0, w_half};
         OP_LW:   w_load = ram_data_i;
         default: w_load = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign w_accept    = rst & r_rst_q & ~flush_i & req_i & (r_state == ST_IDLE);
   assign w_in_access = rst & (r_state == ST_ACCESS);

   assign stallreq_o  = w_accept | (w_in_access & ~flush_i);
   // rst and flush_i gate the enable combinationally so a reset or flush
   // landing in ACCESS cannot commit a write at that edge.
   assign ram_ce_o    = w_in_access & ~flush_i & ~w_misalign;
   assign ram_we_o    = ram_ce_o & w_is_store;
   assign ram_addr_o  = w_in_access ? {r_addr[31:2], 2'b00} : 32'd0;
   assign ram_sel_o   = (w_in_access & ~w_misalign) ? w_sel : 4'b0000;
   assign ram_data_o  = (w_in_access & ~w_misalign) ? w_wdata : 32'd0;
   assign done_o      = rst & ~flush_i & (r_state == ST_DONE);
   assign align_exc_o = done_o & r_align;
   assign rdata_o     = rst ? r_rdata : 32'd0;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_op    <= 3'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_align <= 1'b0;
         r_rst_q <= 1'b0;
      end else begin
         r_rst_q <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= mem_op_i;
                  r_addr  <= addr_i;
                  r_wdata <= wdata_i;
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (flush_i) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_align <= w_misalign;
                  r_rdata <= (w_misalign | w_is_store) ? 32'd0 : w_load;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (flush_i || !stall_i) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl -- directed bench for dmem_ctrl with a behavioural data RAM.
// The RAM is 64 words, big-endian lanes (ram_sel_o[3] -> bits [31:24]).
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic [2:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        align_exc_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  int n_checks;
  int n_errors;
  int n_acc;
  int acc0;
  logic init_mem;
  logic [31:0] mem [0:63];

  dmem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .mem_op_i    (mem_op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .stallreq_o  (stallreq_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .align_exc_o (align_exc_o),
    .ram_ce_o    (ram_ce_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_sel_o   (ram_sel_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i)
  );

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------- RAM model
  assign ram_data_i = mem[ram_addr_o[7:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[8] <= 32'h80FF7F01;
      n_acc  <= 0;
    end else begin
      if (ram_ce_o) n_acc <= n_acc + 1;
      if (ram_ce_o && ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":stallreq"}, {31'd0, stallreq_o}, 32'd0);
    chk({tag, ":done"},     {31'd0, done_o},     32'd0);
    chk({tag, ":rdata"},    rdata_o,             32'd0);
    chk({tag, ":align"},    {31'd0, align_exc_o}, 32'd0);
    chk({tag, ":ce"},       {31'd0, ram_ce_o},   32'd0);
    chk({tag, ":we"},       {31'd0, ram_we_o},   32'd0);
    chk({tag, ":addr"},     ram_addr_o,          32'd0);
    chk({tag, ":sel"},      {28'd0, ram_sel_o},  32'd0);
    chk({tag, ":wdata"},    ram_data_o,          32'd0);
  endtask

  // Called just after a posedge with the DUT in IDLE; returns in IDLE.
  task automatic do_access(input string tag, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_ce, input logic exp_we,
                           input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rdata, input logic exp_align);
    mem_op_i = op; addr_i = addr; wdata_i = wdata; req_i = 1'b1;
    #1;
    chk({tag, ":stallreq_accept"}, {31'd0, stallreq_o}, 32'd1);
    tick();
    req_i = 1'b0;
    #1;
    chk({tag, ":ce"},              {31'd0, ram_ce_o},   {31'd0, exp_ce});
    chk({tag, ":we"},              {31'd0, ram_we_o},   {31'd0, exp_we});
    chk({tag, ":stallreq_access"}, {31'd0, stallreq_o}, 32'd1);
    chk({tag, ":done_access"},     {31'd0, done_o},     32'd0);
    if (exp_ce) begin
      chk({tag, ":addr"},  ram_addr_o, {addr[31:2], 2'b00});
      chk({tag, ":sel"},   {28'd0, ram_sel_o}, {28'd0, exp_sel});
      chk({tag, ":wdata"}, ram_data_o, exp_wd);
    end
    tick();
    chk({tag, ":done"},          {31'd0, done_o},      32'd1);
    chk({tag, ":rdata"},         rdata_o,              exp_rdata);
    chk({tag, ":align"},         {31'd0, align_exc_o}, {31'd0, exp_align});
    chk({tag, ":stallreq_done"}, {31'd0, stallreq_o},  32'd0);
    tick();
    chk({tag, ":done_after"},  {31'd0, done_o},      32'd0);
    chk({tag, ":align_after"}, {31'd0, align_exc_o}, 32'd0);
  endtask

  // ---------------------------------------------------------- directed steps
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; init_mem = 1'b1;
    req_i = 1'b1; mem_op_i = OP_SW; addr_i = 32'h10; wdata_i = 32'hFFFFFFFF;
    stall_i = 1'b0; flush_i = 1'b0;

    // Reset: outputs 0 while held, even with a request pending.
    tick();
    tick();
    chk_zero("in_reset");
    rst = 1'b1; init_mem = 1'b0;
    #1;
    chk_zero("first_after_reset");
    tick();
    req_i = 1'b0;
    tick();
    tick();

    // SW then LW at 0x10.
    do_access("sw_10", OP_SW, 32'h10, 32'hA1B2C3D4, 1, 1, 4'b1111, 32'hA1B2C3D4, 32'd0, 0);
    chk("mem_10_after_sw", mem[4], 32'hA1B2C3D4);
    do_access("lw_10", OP_LW, 32'h10, 32'h0, 1, 0, 4'b1111, 32'd0, 32'hA1B2C3D4, 0);

    // Loads from 0x80FF7F01 at 0x20.
    do_access("lb_21",  OP_LB,  32'h21, 32'h0, 1, 0, 4'b0100, 32'd0, 32'hFFFFFFFF, 0);
    do_access("lbu_21", OP_LBU, 32'h21, 32'h0, 1, 0, 4'b0100, 32'd0, 32'h000000FF, 0);
    do_access("lh_22",  OP_LH,  32'h22, 32'h0, 1, 0, 4'b0011, 32'd0, 32'h00007F01, 0);
    do_access("lb_20",  OP_LB,  32'h20, 32'h0, 1, 0, 4'b1000, 32'd0, 32'hFFFFFF80, 0);
    do_access("lh_20",  OP_LH,  32'h20, 32'h0, 1, 0, 4'b1100, 32'd0, 32'hFFFF80FF, 0);
    do_access("lbu_23", OP_LBU, 32'h23, 32'h0, 1, 0, 4'b0001, 32'd0, 32'h00000001, 0);

    // Byte and halfword stores.
    do_access("sb_23", OP_SB, 32'h23, 32'hABCDEF55, 1, 1, 4'b0001, 32'h55555555, 32'd0, 0);
    chk("mem_20_after_sb", mem[8], 32'h80FF7F55);
    do_access("sh_20", OP_SH, 32'h20, 32'h00001234, 1, 1, 4'b1100, 32'h12341234, 32'd0, 0);
    chk("mem_20_after_sh", mem[8], 32'h12347F55);
    do_access("lhu_20", OP_LHU, 32'h20, 32'h0, 1, 0, 4'b1100, 32'd0, 32'h00001234, 0);

    // Misaligned accesses: no RAM cycle, exception in DONE.
    acc0 = n_acc;
    do_access("lw_22_mis", OP_LW, 32'h22, 32'h0, 0, 0, 4'b0000, 32'd0, 32'd0, 1);
    do_access("sh_21_mis", OP_SH, 32'h21, 32'h0000FFFF, 0, 0, 4'b0000, 32'd0, 32'd0, 1);
    chk("mem_20_after_mis", mem[8], 32'h12347F55);
    chk("acc_count_mis", n_acc - acc0, 32'd0);

    // Load held in DONE by stall_i for 3 cycles.
    acc0 = n_acc;
    mem_op_i = OP_LW; addr_i = 32'h10; wdata_i = 32'h0; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    stall_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_done", {31'd0, done_o}, 32'd1);
      chk("stall_rdata", rdata_o, 32'hA1B2C3D4);
      chk("stall_stallreq", {31'd0, stallreq_o}, 32'd0);
      tick();
    end
    stall_i = 1'b0;
    #1;
    chk("stall_done_last", {31'd0, done_o}, 32'd1);
    chk("stall_rdata_last", rdata_o, 32'hA1B2C3D4);
    tick();
    chk("stall_done_after", {31'd0, done_o}, 32'd0);
    chk("stall_acc_count", n_acc - acc0, 32'd1);

    // Request together with flush in IDLE is ignored.
    mem_op_i = OP_SW; addr_i = 32'h30; wdata_i = 32'h11223344;
    req_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("idle_flush_stallreq", {31'd0, stallreq_o}, 32'd0);
    tick();
    req_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("idle_flush_no_access", {31'd0, ram_ce_o}, 32'd0);
    chk("idle_flush_stallreq2", {31'd0, stallreq_o}, 32'd0);
    tick();

    // Flush during ACCESS of SW 0x30.
    req_i = 1'b1;
    tick();
    req_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("flush_acc_ce", {31'd0, ram_ce_o}, 32'd0);
    chk("flush_acc_we", {31'd0, ram_we_o}, 32'd0);
    chk("flush_acc_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("flush_acc_done", {31'd0, done_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_next_done", {31'd0, done_o}, 32'd0);
    chk("flush_next_ce", {31'd0, ram_ce_o}, 32'd0);
    chk("flush_next_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("flush_mem_30", mem[12], 32'd0);
    tick();
    chk("flush_idle_done", {31'd0, done_o}, 32'd0);

    // Reset during ACCESS of SW 0x34.
    mem_op_i = OP_SW; addr_i = 32'h34; wdata_i = 32'hDEADBEEF; req_i = 1'b1;
    tick();
    req_i = 1'b0; rst = 1'b0;
    #1;
    chk_zero("rst_in_access");
    tick();
    rst = 1'b1;
    #1;
    chk_zero("rst_after_access");
    chk("rst_mem_34", mem[13], 32'd0);
    tick();
    tick();

    // Controller recovers after reset.
    do_access("lw_10_post_rst", OP_LW, 32'h10, 32'h0, 1, 0, 4'b1111, 32'd0, 32'hA1B2C3D4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
